// File: rtl/gf_comp_pkg.sv
// Shared GF(2^2)/GF(2^4) composite-field types and arithmetic helpers.
// GF(2^2) uses polynomial basis w^2 = w + 1, element {a1,a0} = a1*w + a0.
package gf_comp_pkg;
  typedef logic [1:0] gf2_t;
  typedef logic [3:0] gf4_t;

  localparam gf2_t GF4_LAMBDA = 2'b10;

  function automatic gf2_t gf2_mul(input gf2_t a, input gf2_t b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // Squaring is linear in characteristic 2: (a1*w + a0)^2 = a1*w^2 + a0.
  function automatic gf2_t gf2_sq(input gf2_t a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic gf2_t gf2_scale_lambda(input gf2_t a, input gf2_t lam);
    return gf2_mul(a, lam);
  endfunction
endpackage

// File: rtl/gf2_inv.sv
// GF(2^2) inverter; in characteristic 2 with w^2=w+1 the inverse equals the square.
module gf2_inv
  import gf_comp_pkg::*;
(
  input  gf2_t i_x,
  output gf2_t o_y
);
  assign o_y = {i_x[1], i_x[1] ^ i_x[0]};
endmodule

// File: rtl/gf4_inv_lane.sv
// Combinational per-lane math: stage-1 norm d and stage-2 GF(2^4) inverse from registered ah/al/d.
module gf4_inv_lane
  import gf_comp_pkg::*;
#(
  parameter gf2_t LAMBDA = GF4_LAMBDA
) (
  input  gf4_t i_a,
  output gf2_t o_d,
  input  gf2_t i_ah,
  input  gf2_t i_al,
  input  gf2_t i_d,
  output gf4_t o_inv
);
  gf2_t w_dinv;

  assign o_d = gf2_scale_lambda(gf2_sq(i_a[3:2]), LAMBDA)
             ^ gf2_mul(i_a[3:2], i_a[1:0])
             ^ gf2_sq(i_a[1:0]);

  gf2_inv u_inv (.i_x(i_d), .o_y(w_dinv));

  assign o_inv = {gf2_mul(i_ah, w_dinv), gf2_mul(i_ah ^ i_al, w_dinv)};
endmodule

// File: rtl/gf4_inv_pipe.sv
// Two-stage valid/ready GF(2^4) inverter, LANES nibbles per beat.
// Stage 1 registers ah/al/d, stage 2 registers the inverse; a full pipe shifts with no bubble.
module gf4_inv_pipe
  import gf_comp_pkg::*;
#(
  parameter int   LANES  = 1,
  parameter gf2_t LAMBDA = GF4_LAMBDA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*LANES-1:0] out_data
);
  logic [2:1] r_vld_pipe;
  logic [LANES-1:0][1:0] r_s1_ah, r_s1_al, r_s1_d;
  logic [LANES-1:0][3:0] r_out;

  logic [LANES-1:0][3:0] w_in, w_inv;
  logic [LANES-1:0][1:0] w_d;
  logic w_s1_en, w_s2_en;

  assign w_in = in_data;

  assign w_s2_en   = !r_vld_pipe[2] || out_ready;
  assign w_s1_en   = !r_vld_pipe[1] || w_s2_en;
  assign in_ready  = w_s1_en;
  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_out;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gf4_inv_lane #(.LAMBDA(LAMBDA)) u_lane (
      .i_a  (w_in[g]),
      .o_d  (w_d[g]),
      .i_ah (r_s1_ah[g]),
      .i_al (r_s1_al[g]),
      .i_d  (r_s1_d[g]),
      .o_inv(w_inv[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_ah    <= '0;
      r_s1_al    <= '0;
      r_s1_d     <= '0;
      r_out      <= '0;
    end else begin
      if (w_s1_en) begin
        r_vld_pipe[1] <= in_valid;
        for (int i = 0; i < LANES; i++) begin
          r_s1_ah[i] <= w_in[i][3:2];
          r_s1_al[i] <= w_in[i][1:0];
          r_s1_d[i]  <= w_d[i];
        end
      end
      if (w_s2_en) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        r_out         <= w_inv;
      end
    end
  end
endmodule

// File: tb/tb_gf4_inv_pipe.sv
// Randomized + directed bench for gf4_inv_pipe (LANES=4) against a search-based GF(2^4) inverse model.
module tb_gf4_inv_pipe;
  localparam int LANES = 4;
  localparam int W = 4 * LANES;
  localparam logic [1:0] LAM = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;

  gf4_inv_pipe #(.LANES(LANES), .LAMBDA(LAM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit lat_mode = 0;
  bit prod_mode = 0;

  logic [W-1:0] q_data[$];
  int           q_cyc[$];
  bit           q_lat[$];

  // GF(2^2) as polynomials over GF(2) reduced modulo x^2 + x + 1.
  function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] p;
    p = (b[0] ? {1'b0, a} : 3'b0) ^ (b[1] ? {a, 1'b0} : 3'b0);
    if (p[2]) p = p ^ 3'b111;
    return p[1:0];
  endfunction

  // (ah v + al)(bh v + bl) with v^2 = v + lambda.
  function automatic logic [3:0] m4(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] hh;
    hh = m2(x[3:2], y[3:2]);
    return {hh ^ m2(x[3:2], y[1:0]) ^ m2(x[1:0], y[3:2]), m2(hh, LAM) ^ m2(x[1:0], y[1:0])};
  endfunction

  function automatic logic [3:0] inv4(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int y = 1; y < 16; y++) if (m4(x, 4'(y)) == 4'h1) r = 4'(y);
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[4*i +: 4] = inv4(d[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard and hold checks, sampled mid-cycle when everything is settled.
  logic [W-1:0] prev_data;
  bit hold_prev = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_data.delete(); q_cyc.delete(); q_lat.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (in_valid && in_ready) begin
        q_data.push_back(in_data); q_cyc.push_back(cyc); q_lat.push_back(lat_mode);
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hDEAD);
        end else begin
          logic [W-1:0] d; int c; bit l;
          d = q_data.pop_front(); c = q_cyc.pop_front(); l = q_lat.pop_front();
          chk("out_data", 32'(out_data), 32'(model(d)));
          if (l) chk("latency", 32'(cyc - c), 32'd2);
          if (prod_mode)
            for (int i = 0; i < LANES; i++)
              chk("x_times_inv", 32'(m4(d[4*i +: 4], out_data[4*i +: 4])),
                  (d[4*i +: 4] == 4'h0) ? 32'h0 : 32'h1);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // One cycle of stimulus; also proves in_ready ignores in_valid.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, output bit acc);
    logic ir0;
    @(posedge clk); #1;
    out_ready = ordy; in_data = d; in_valid = !v; #1;
    ir0 = in_ready;
    in_valid = v; #1;
    chk("in_ready_indep", 32'(in_ready), 32'(ir0));
    acc = v && in_ready;
  endtask

  task automatic send(input logic [W-1:0] d, input logic ordy, output int tries);
    bit acc;
    tries = 0;
    do begin
      drive(1'b1, d, ordy, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk("send_timeout", 32'(tries), 32'd0);
  endtask

  task automatic idle(input logic ordy);
    bit acc;
    drive(1'b0, $urandom(), ordy, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_data.size() != 0 && n < 50) begin idle(1'b1); n++; end
    chk("drain", 32'(q_data.size()), 32'd0);
  endtask

  initial begin
    int t;
    bit acc;
    logic [W-1:0] d;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0; #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single beat: lanes 0..3 = 0,1,2,4 -> 0,1,3,F after exactly two cycles.
    lat_mode = 1;
    send(16'h4210, 1'b1, t);
    idle(1'b1);
    chk("dir_not_early", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("dir_valid", 32'(out_valid), 32'd1);
    chk("dir_data", 32'(out_data), 32'hF310);
    drain();

    // All 16 values back-to-back in every lane, no bubbles.
    prod_mode = 1;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < LANES; i++) d[4*i +: 4] = 4'((k + 5 * i) % 16);
      send(d, 1'b1, t);
      chk("no_bubble", 32'(t), 32'd1);
    end
    drain();
    prod_mode = 0;
    lat_mode = 0;

    // Backpressure: two beats fill the pipe, third waits for release.
    send({4{4'h2}}, 1'b0, t);
    send({4{4'h4}}, 1'b0, t);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, {4{4'h1}}, 1'b0, acc);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h3333);
    end
    send({4{4'h1}}, 1'b1, t);
    drain();

    // Mid-stream reset with two beats in flight.
    send(16'h1234, 1'b1, t);
    send(16'h5678, 1'b1, t);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #2;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) idle(1'b1);

    // Random valid/ready traffic.
    t = 0;
    for (int n = 0; n < 4000 && t < 1000; n++) begin
      drive(($urandom_range(0, 3) != 0), W'($urandom()), ($urandom_range(0, 2) != 0), acc);
      if (acc) t++;
    end
    chk("rand_beats", 32'(t), 32'd1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/gf4_inv_pipe.md
Name: gf4_inv_pipe

Overview:
- Two-stage pipelined GF(2^4) inverter for the composite-field AES S-box.
- Sits directly upstream of the GF(2^2) inverter. Stage 1 reduces each nibble to its GF(2^2) "norm" d. Stage 2 inverts d with the existing gf2_inv and forms the GF(2^4) inverse.
- Accepts LANES nibbles per beat, with valid/ready flow control so the S-box pipeline can stall.

Parameters:
- LANES, 1, number of independent 4-bit lanes processed per beat.
- LAMBDA, 2'b10, GF(2^2) constant λ in the field polynomial v^2+v+λ (λ = w; must be 2'b10 or 2'b11).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  4*LANES  lane i = in_data[4i+3:4i] = {ah[1:0], al[1:0]}.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  4*LANES  per-lane GF(2^4) inverse, same packing as in_data.

Behaviour:
- GF(2^2) arithmetic, polynomial basis w^2=w+1, element {a1,a0}:
  - mul: hi = a1b1^a1b0^a0b1; lo = a1b1^a0b0.
  - inverse: {x1, x1^x0}, via gf2_inv.
- GF(2^4) element a = ah·v + al, reduced by v^2 = v + λ.
- Stage 1, per lane:
  - d = λ·ah^2 ^ ah·al ^ al^2.
  - Register s1_ah, s1_al, s1_d and s1_valid.
- Stage 2, per lane:
  - dinv = gf2_inv(s1_d).
  - out hi = ah·dinv; out lo = (ah^al)·dinv.
  - Register into out_data and out_valid.
- Zero input maps to zero (d=0, dinv=0): no special case, no error flag.
- Latency: exactly 2 cycles from accepted input to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Handshake:
  - A transfer occurs when valid&&ready.
  - in_valid/in_data may change freely while in_ready=0.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Flow control:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, purely combinational from register state and out_ready. in_ready never depends on in_valid.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 shifts all stages in the same cycle with no bubble.
- Reset, including mid-operation:
  - s1_valid=0, out_valid=0, out_data=0, s1 data registers=0.
  - In-flight beats are discarded.
  - in_ready=1 in the first cycle after rst is deasserted.
- Data registers update only on their stage enable. Invalid stages may hold stale data; out_data is observed only when out_valid=1.

Decomposition:
- Package gf_comp_pkg holds:
  - typedefs gf2_t (logic [1:0]) and gf4_t (logic [3:0]).
  - constant GF4_LAMBDA = 2'b10.
  - functions gf2_mul, gf2_sq, gf2_scale_lambda.
- One sub-module: gf4_inv_lane, the combinational per-lane stage-1 and stage-2 math, instantiating gf2_inv.
- The top generates LANES instances of gf4_inv_lane and holds the shared pipeline registers and handshake logic.

Test Plan:
- Reset then single beats (LANES=1), out_ready=1: in 4'h0→4'h0, 4'h1→4'h1, 4'h2→4'h3, 4'h4→4'hF. Each appears exactly 2 cycles after acceptance.
- Exhaustive check: all 16 inputs streamed back-to-back. For x≠0, GF(2^4) product x·out=4'h1 via a reference model. Zero maps to zero. out_valid is continuous after the 2-cycle fill.
- Backpressure: stream 4'h2, 4'h4, 4'h1 with out_ready=0 from cycle 2.
  - out_data holds 4'h3 and in_ready drops to 0 once both stages are full.
  - The third beat is held off until released.
  - After out_ready=1, outputs 4'h3, 4'hF, 4'h1 arrive in order, with no loss or duplication.
- Random valid/ready toggling, LANES=4, 1000 beats: scoreboard order and values match. in_ready never depends on in_valid.
- Mid-stream reset with 2 beats in flight: next cycle out_valid=0 and out_data=0. Cycle after deassertion in_ready=1. Stale beats never emerge.
- Full pipeline with out_ready=1 and in_valid=1 simultaneously: a new beat is accepted every cycle with zero bubbles.
